irq_dispatcher: RTL and testbench
=================================

// Module: irq_dispatcher
// PURPOSE
//  Sequences interrupt delivery between peripheral IRQ lines, the ISR-address controller and the core.
//  Synchronises and latches requests, applies the controller's mask and picks one winner by fixed priority.
//  Drives the controller's source inputs one-hot-low so its ISR address output is the winner's vector.
//  Runs a req/ack/ret handshake with the core; no nesting. Pending/status/config are memory-mapped at 0x4006-0x4008.
// PARAMETERS
//  NUM_SRC      5         number of IRQ sources; index 4 is highest priority
//  SYNC_STAGES  2         synchroniser depth on raw source lines
//  BASE_ADDR    32'h4006  address of PENDING; ACTIVE = +1, CONFIG = +2
// PORTS
//  clk             in     1        clock
//  reset           in     1        asynchronous, active-low
//  irq_raw_n       in     NUM_SRC  raw peripheral IRQ lines, active-low, asynchronous
//  irq_mask        in     NUM_SRC  enable mask from the ISR-address controller, 1 = enabled
//  irq_sel_n       out    NUM_SRC  one-hot-low winner select; feeds the controller's source inputs
//  irq_target_in   in     32       ISR address returned by the controller for irq_sel_n
//  cpu_irq_req     out    1        interrupt request to the core
//  cpu_irq_vector  out    32       ISR address; stable while cpu_irq_req=1
//  cpu_irq_ack     in     1        1-cycle pulse: the core has taken the vector
//  cpu_irq_ret     in     1        1-cycle pulse: ISR return
//  data_bus_data   inout  32       shared data bus; driven only while a read hits this block, else 'z
//  data_bus_addr   in     32       bus address
//  data_bus_mode   in     2        01 = read, 10 = write, other = idle
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, config=0 (all level), sync flops=1, irq_sel_n=all 1, cpu_irq_req=0, cpu_irq_vector=0.
//  Sync: irq_raw_n goes through SYNC_STAGES flops. sync_q holds the synchronised value; sync_prev holds sync_q one cycle later.
//  Edge source (CONFIG bit=1): pending[i] sets when sync_prev[i]=1 and sync_q[i]=0.
//    pending[i] clears on ack of i, or on a bus write of 1 to PENDING[i].
//    If a set and a clear hit the same cycle, set wins.
//  Level source (CONFIG bit=0): pending[i] = ~sync_q[i] every cycle. W1C and ack have no effect.
//  Eligible = pending & irq_mask. Winner = highest set index.
//  FSM:
//    IDLE    -> SELECT  when eligible!=0. Register sel_idx; drive irq_sel_n[sel_idx]=0, all other bits 1.
//    SELECT  -> REQ     unconditionally. cpu_irq_vector <= irq_target_in; cpu_irq_req <= 1.
//    REQ     -> SERVICE on cpu_irq_ack. cpu_irq_req <= 0; clear edge pending[sel_idx].
//    REQ     -> IDLE    if irq_mask[sel_idx]=0 and no ack. Drop cpu_irq_req; keep pending; irq_sel_n <= all 1.
//    SERVICE -> IDLE    on cpu_irq_ret. irq_sel_n <= all 1.
//  Ack and mask-clear in the same cycle: ack wins.
//  Ack outside REQ is ignored. Ret outside SERVICE is ignored.
//  Higher-priority arrivals during REQ/SERVICE stay pending; no pre-emption. Arbitration happens only in IDLE.
//  Level source still low after ret: it is re-requested through IDLE->SELECT.
//  Latency: cpu_irq_req=1 on the SYNC_STAGES+3rd rising edge after irq_raw_n falls (5 edges at default).
//  Registers (decode BASE_ADDR..BASE_ADDR+2):
//    PENDING: read [NUM_SRC-1:0]; write = W1C.
//    ACTIVE (read-only): [7]=state in REQ/SERVICE, [2:0]=sel_idx.
//    CONFIG: R/W [NUM_SRC-1:0], 1 = edge.
//    Reads are combinational; unused bits read 0; writes to ACTIVE are ignored.
//  Reset mid-handshake: immediate return to reset values; the core must treat loss of cpu_irq_req as withdrawal.
// STRUCTURE
//  Package irq_pkg: NUM_SRC, state enum (IDLE/SELECT/REQ/SERVICE), register offsets, bus mode codes 01/10.
//  Sub-module irq_sync: per-bit flop-chain synchroniser, parameter STAGES, reset value 1.
//  Priority encoder is a local function. All other logic sits in irq_dispatcher.
// TESTING
//  T1 CONFIG=5'h01, mask=5'h01, irq_raw_n[0] pulsed low 1 cycle, irq_target_in=0x100
//     -> irq_sel_n=5'h1E; cpu_irq_req rises 5 edges after the pulse with vector 0x100;
//     -> ack clears PENDING; ret returns ACTIVE to 0.
//  T2 Sources 1 and 3 pending together, mask=5'h1F -> winner 3 (irq_sel_n=5'h17); after ret, source 1 is served.
//  T3 In REQ for source 2, write mask=0 -> cpu_irq_req drops next edge, PENDING[2] stays 1, irq_sel_n=5'h1F.
//  T4 Level source 4 held low across ret -> re-requested; release before ret -> FSM stays in IDLE.
//  T5 Edge on source 0 in the same cycle as W1C of PENDING[0] -> PENDING[0]=1.
//     -> Bus read of 0x4008 returns CONFIG; read of an address outside 0x4006-0x4008 leaves the bus 'z.
//  T6 reset asserted in SERVICE -> all outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt dispatcher: source count,
// synchroniser depth, register map and bus mode codes.
package irq_pkg;

   localparam int          NUM_SRC     = 5;
   localparam int          SYNC_STAGES = 2;
   localparam logic [31:0] BASE_ADDR   = 32'h4006;

   localparam logic [1:0] OFF_PENDING = 2'd0;
   localparam logic [1:0] OFF_ACTIVE  = 2'd1;
   localparam logic [1:0] OFF_CONFIG  = 2'd2;

   localparam logic [1:0] MODE_READ  = 2'b01;
   localparam logic [1:0] MODE_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SELECT  = 2'd1,
      REQ     = 2'd2,
      SERVICE = 2'd3
   } state_t;

endpackage

// File: rtl/irq_sync.sv
// Per-bit flop-chain synchroniser for asynchronous active-low lines.
// Resets to 1 so an idle (high) line never looks like a fresh request.
module irq_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '1;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_dispatcher.sv
// Latches peripheral IRQs, picks a masked fixed-priority winner, steers the
// ISR-address controller via irq_sel_n and runs a req/ack/ret handshake with the core.
module irq_dispatcher #(
   parameter int          NUM_SRC     = irq_pkg::NUM_SRC,
   parameter int          SYNC_STAGES = irq_pkg::SYNC_STAGES,
   parameter logic [31:0] BASE_ADDR   = irq_pkg::BASE_ADDR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_raw_n,
   input  logic [NUM_SRC-1:0] irq_mask,
   output logic [NUM_SRC-1:0] irq_sel_n,
   input  logic [31:0]        irq_target_in,
   output logic               cpu_irq_req,
   output logic [31:0]        cpu_irq_vector,
   input  logic               cpu_irq_ack,
   input  logic               cpu_irq_ret,
   inout  wire  [31:0]        data_bus_data,
   input  logic [31:0]        data_bus_addr,
   input  logic [1:0]         data_bus_mode
);

   import irq_pkg::*;

   state_t             state, state_next;
   logic [2:0]         sel_idx, sel_idx_next;
   logic [NUM_SRC-1:0] sel_n_next;
   logic               req_next;
   logic [31:0]        vec_next;
   logic               ack_clear;

   logic [NUM_SRC-1:0] sync_q, sync_prev, pending, pending_next, config_q;
   logic [NUM_SRC-1:0] fall, eligible, w1c, ack_vec;

   logic        addr_hit, rd_hit, wr_hit;
   logic [1:0]  offset;
   logic [31:0] rd_data;

   function automatic logic [2:0] prio_enc(input logic [NUM_SRC-1:0] v);
      prio_enc = '0;
      for (int i = 0; i < NUM_SRC; i++) if (v[i]) prio_enc = 3'(i);
   endfunction

   irq_sync #(.WIDTH(NUM_SRC), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_raw_n),
      .q     (sync_q)
   );

   assign addr_hit = (data_bus_addr >= BASE_ADDR) && (data_bus_addr <= BASE_ADDR + 32'd2);
   assign offset   = 2'(data_bus_addr - BASE_ADDR);
   assign rd_hit   = addr_hit && (data_bus_mode == MODE_READ);
   assign wr_hit   = addr_hit && (data_bus_mode == MODE_WRITE);

   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_PENDING: rd_data[NUM_SRC-1:0] = pending;
         OFF_ACTIVE: begin
            rd_data[7]   = (state == REQ) || (state == SERVICE);
            rd_data[2:0] = sel_idx;
         end
         OFF_CONFIG:  rd_data[NUM_SRC-1:0] = config_q;
         default:     rd_data = '0;
      endcase
   end

   assign data_bus_data = rd_hit ? rd_data : 'z;

   // Edge sources: a new falling edge beats any same-cycle clear; level sources track the line.
   assign fall         = sync_prev & ~sync_q;
   assign w1c          = (wr_hit && offset == OFF_PENDING) ? data_bus_data[NUM_SRC-1:0] : '0;
   assign ack_vec      = ack_clear ? (NUM_SRC'(1) << sel_idx) : '0;
   assign pending_next = (config_q & (fall | (pending & ~(w1c | ack_vec)))) | (~config_q & ~sync_q);
   assign eligible     = pending & irq_mask;

   always_comb begin
      state_next   = state;
      sel_idx_next = sel_idx;
      sel_n_next   = irq_sel_n;
      req_next     = cpu_irq_req;
      vec_next     = cpu_irq_vector;
      ack_clear    = 1'b0;
      case (state)
         IDLE: begin
            if (|eligible) begin
               state_next   = SELECT;
               sel_idx_next = prio_enc(eligible);
               sel_n_next   = ~(NUM_SRC'(1) << prio_enc(eligible));
            end
         end
         SELECT: begin
            state_next = REQ;
            vec_next   = irq_target_in;
            req_next   = 1'b1;
         end
         REQ: begin
            if (cpu_irq_ack) begin
               state_next = SERVICE;
               req_next   = 1'b0;
               ack_clear  = 1'b1;
            end else if (!irq_mask[sel_idx]) begin
               state_next = IDLE;
               req_next   = 1'b0;
               sel_n_next = '1;
            end
         end
         SERVICE: begin
            if (cpu_irq_ret) begin
               state_next = IDLE;
               sel_n_next = '1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         sel_idx        <= '0;
         irq_sel_n      <= '1;
         cpu_irq_req    <= 1'b0;
         cpu_irq_vector <= '0;
         sync_prev      <= '1;
         pending        <= '0;
         config_q       <= '0;
      end else begin
         state          <= state_next;
         sel_idx        <= sel_idx_next;
         irq_sel_n      <= sel_n_next;
         cpu_irq_req    <= req_next;
         cpu_irq_vector <= vec_next;
         sync_prev      <= sync_q;
         pending        <= pending_next;
         if (wr_hit && offset == OFF_CONFIG) config_q <= data_bus_data[NUM_SRC-1:0];
      end
   end

endmodule

// File: tb/tb_irq_dispatcher.sv
// Bench for irq_dispatcher: acts as the peripherals, the ISR-address controller,
// the core and the bus master, and predicts service order from priority rules.
module tb_irq_dispatcher;

   localparam int N = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  irq_raw_n = '1;
   logic [N-1:0]  irq_mask = '0;
   wire  [N-1:0]  irq_sel_n;
   logic [31:0]   irq_target_in;
   wire           cpu_irq_req;
   wire  [31:0]   cpu_irq_vector;
   logic          cpu_irq_ack = 1'b0;
   logic          cpu_irq_ret = 1'b0;
   wire  [31:0]   data_bus_data;
   logic [31:0]   data_bus_addr = '0;
   logic [1:0]    data_bus_mode = 2'b00;
   logic          drv_en = 1'b0;
   logic [31:0]   drv_data = '0;

   int checks = 0;
   int errors = 0;

   assign data_bus_data = drv_en ? drv_data : 'z;

   irq_dispatcher dut (
      .clk            (clk),
      .reset          (reset),
      .irq_raw_n      (irq_raw_n),
      .irq_mask       (irq_mask),
      .irq_sel_n      (irq_sel_n),
      .irq_target_in  (irq_target_in),
      .cpu_irq_req    (cpu_irq_req),
      .cpu_irq_vector (cpu_irq_vector),
      .cpu_irq_ack    (cpu_irq_ack),
      .cpu_irq_ret    (cpu_irq_ret),
      .data_bus_data  (data_bus_data),
      .data_bus_addr  (data_bus_addr),
      .data_bus_mode  (data_bus_mode)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // controller model: vector for source i is 0x100 + 0x40*i
   function automatic logic [31:0] target_of(input int idx);
      return 32'h100 + 32'(idx) * 32'h40;
   endfunction

   always_comb begin
      irq_target_in = '0;
      for (int i = 0; i < N; i++) if (irq_sel_n[i] == 1'b0) irq_target_in = target_of(i);
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      data_bus_addr = a;
      data_bus_mode = 2'b01;
      #1;
      d = data_bus_data;
      data_bus_mode = 2'b00;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      data_bus_addr = a;
      drv_data      = d;
      drv_en        = 1'b1;
      data_bus_mode = 2'b10;
      step();
      drv_en        = 1'b0;
      data_bus_mode = 2'b00;
   endtask

   task automatic pulse_ack();
      cpu_irq_ack = 1'b1;
      step();
      cpu_irq_ack = 1'b0;
   endtask

   task automatic pulse_ret();
      cpu_irq_ret = 1'b1;
      step();
      cpu_irq_ret = 1'b0;
   endtask

   task automatic pulse_src(input logic [N-1:0] srcs);
      irq_raw_n = ~srcs;
      step();
      irq_raw_n = '1;
   endtask

   task automatic wait_req(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (cpu_irq_req === 1'b1) ok = 1'b1;
         else step();
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_wait_req: got no request expected request", name); end
   endtask

   // scenarios
   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", cpu_irq_req); end
      checks++; if (cpu_irq_vector !== 32'h0) begin errors++; $display("FAIL rst_vector: got %h expected 0", cpu_irq_vector); end
      checks++; if (irq_sel_n !== 5'h1F) begin errors++; $display("FAIL rst_sel_n: got %h expected 1f", irq_sel_n); end
      reset = 1'b1;
      step();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h expected 0", d); end
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_active: got %h expected 0", d); end
      bus_read(32'h4008, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_config: got %h expected 0", d); end
   endtask

   task automatic test_edge_single();
      logic [31:0] d;
      bus_write(32'h4008, 32'h01);
      irq_mask = 5'h01;
      step();
      irq_raw_n[0] = 1'b0;
      step();
      irq_raw_n[0] = 1'b1;
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL t1_req_e1: got %b expected 0", cpu_irq_req); end
      step();
      step();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL t1_pending_set: got %h expected 1", d); end
      step();
      checks++; if (irq_sel_n !== 5'h1E) begin errors++; $display("FAIL t1_sel_n: got %h expected 1e", irq_sel_n); end
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL t1_req_e4: got %b expected 0", cpu_irq_req); end
      step();
      checks++; if (cpu_irq_req !== 1'b1) begin errors++; $display("FAIL t1_req_e5: got %b expected 1", cpu_irq_req); end
      checks++; if (cpu_irq_vector !== 32'h100) begin errors++; $display("FAIL t1_vector: got %h expected 100", cpu_irq_vector); end
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h80) begin errors++; $display("FAIL t1_active_req: got %h expected 80", d); end
      pulse_ack();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t1_pending_ack: got %h expected 0", d); end
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h80) begin errors++; $display("FAIL t1_active_svc: got %h expected 80", d); end
      pulse_ret();
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t1_active_ret: got %h expected 0", d); end
      checks++; if (irq_sel_n !== 5'h1F) begin errors++; $display("FAIL t1_sel_n_ret: got %h expected 1f", irq_sel_n); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      bus_write(32'h4008, 32'h1F);
      irq_mask = 5'h1F;
      pulse_src(5'b01010);
      wait_req("t2_first");
      checks++; if (irq_sel_n !== 5'h17) begin errors++; $display("FAIL t2_sel_n_3: got %h expected 17", irq_sel_n); end
      checks++; if (cpu_irq_vector !== target_of(3)) begin errors++; $display("FAIL t2_vector_3: got %h expected %h", cpu_irq_vector, target_of(3)); end
      pulse_ack();
      pulse_ret();
      wait_req("t2_second");
      checks++; if (irq_sel_n !== 5'h1D) begin errors++; $display("FAIL t2_sel_n_1: got %h expected 1d", irq_sel_n); end
      checks++; if (cpu_irq_vector !== target_of(1)) begin errors++; $display("FAIL t2_vector_1: got %h expected %h", cpu_irq_vector, target_of(1)); end
      pulse_ack();
      pulse_ret();
      step();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t2_pending_end: got %h expected 0", d); end
   endtask

   task automatic test_mask_withdraw();
      logic [31:0] d;
      pulse_src(5'b00100);
      wait_req("t3");
      irq_mask = 5'h00;
      step();
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL t3_req_drop: got %b expected 0", cpu_irq_req); end
      checks++; if (irq_sel_n !== 5'h1F) begin errors++; $display("FAIL t3_sel_n: got %h expected 1f", irq_sel_n); end
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL t3_pending_kept: got %h expected 4", d); end
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL t3_active: got %h expected 2", d); end
      irq_mask = 5'h1F;
      wait_req("t3_again");
      checks++; if (irq_sel_n !== 5'h1B) begin errors++; $display("FAIL t3_sel_n_again: got %h expected 1b", irq_sel_n); end
      pulse_ack();
      pulse_ret();
   endtask

   task automatic test_level();
      logic [31:0] d;
      bus_write(32'h4008, 32'h00);
      irq_raw_n[4] = 1'b0;
      wait_req("t4_first");
      checks++; if (cpu_irq_vector !== target_of(4)) begin errors++; $display("FAIL t4_vector: got %h expected %h", cpu_irq_vector, target_of(4)); end
      pulse_ack();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h10) begin errors++; $display("FAIL t4_level_after_ack: got %h expected 10", d); end
      pulse_ret();
      wait_req("t4_rerequest");
      checks++; if (irq_sel_n !== 5'h0F) begin errors++; $display("FAIL t4_sel_n: got %h expected 0f", irq_sel_n); end
      pulse_ack();
      irq_raw_n[4] = 1'b1;
      repeat (4) step();
      pulse_ret();
      repeat (5) step();
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL t4_idle_req: got %b expected 0", cpu_irq_req); end
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL t4_idle_active: got %h expected 4", d); end
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t4_pending_clear: got %h expected 0", d); end
   endtask

   task automatic test_w1c_race();
      logic [31:0] d;
      irq_mask = 5'h00;
      bus_write(32'h4008, 32'h01);
      pulse_src(5'b00001);
      repeat (3) step();
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL t5_pending_set: got %h expected 1", d); end
      bus_write(32'h4006, 32'h1);
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t5_w1c: got %h expected 0", d); end
      irq_raw_n[0] = 1'b0;
      step();
      irq_raw_n[0] = 1'b1;
      step();
      bus_write(32'h4006, 32'h1);
      bus_read(32'h4006, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL t5_set_wins: got %h expected 1", d); end
      bus_write(32'h4006, 32'h1F);
      bus_write(32'h4008, 32'h15);
      bus_read(32'h4008, d);
      checks++; if (d !== 32'h15) begin errors++; $display("FAIL t5_config_rd: got %h expected 15", d); end
      bus_write(32'h4007, 32'hFF);
      bus_read(32'h4007, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL t5_active_ro: got %h expected 4", d); end
      bus_read(32'h4009, d);
      checks++; if (!(d === 32'hzzzzzzzz || d === 32'h0)) begin errors++; $display("FAIL t5_bus_hiz_above: got %h expected z", d); end
      bus_read(32'h4005, d);
      checks++; if (!(d === 32'hzzzzzzzz || d === 32'h0)) begin errors++; $display("FAIL t5_bus_hiz_below: got %h expected z", d); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [N-1:0] s, m;
      int idx;
      int exp_q[$];
      bus_write(32'h4008, 32'h1F);
      for (int it = 0; it < 16; it++) begin
         s = N'($urandom_range(1, 31));
         m = N'($urandom_range(0, 31));
         irq_mask = m;
         step();
         pulse_src(s);
         exp_q.delete();
         for (int i = N - 1; i >= 0; i--) if (s[i] && m[i]) exp_q.push_back(i);
         while (exp_q.size() > 0) begin
            idx = exp_q.pop_front();
            wait_req("rnd");
            checks++; if (irq_sel_n !== ~(N'(1) << idx)) begin errors++; $display("FAIL rnd_sel_n: got %h expected %h (src %0d)", irq_sel_n, ~(N'(1) << idx), idx); end
            checks++; if (cpu_irq_vector !== target_of(idx)) begin errors++; $display("FAIL rnd_vector: got %h expected %h", cpu_irq_vector, target_of(idx)); end
            pulse_ack();
            pulse_ret();
         end
         repeat (4) step();
         checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL rnd_req_idle: got %b expected 0", cpu_irq_req); end
         bus_read(32'h4006, d);
         checks++; if (d !== 32'(s & ~m)) begin errors++; $display("FAIL rnd_pending_left: got %h expected %h", d, 32'(s & ~m)); end
         bus_write(32'h4006, 32'h1F);
      end
   endtask

   task automatic test_reset_async();
      logic [31:0] d;
      irq_mask = 5'h1F;
      pulse_src(5'b01000);
      wait_req("t6");
      pulse_ack();
      #3;
      reset = 1'b0;
      #1;
      checks++; if (cpu_irq_req !== 1'b0) begin errors++; $display("FAIL t6_req: got %b expected 0", cpu_irq_req); end
      checks++; if (irq_sel_n !== 5'h1F) begin errors++; $display("FAIL t6_sel_n: got %h expected 1f", irq_sel_n); end
      checks++; if (cpu_irq_vector !== 32'h0) begin errors++; $display("FAIL t6_vector: got %h expected 0", cpu_irq_vector); end
      bus_read(32'h4008, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL t6_config: got %h expected 0", d); end
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_edge_single();
      test_priority();
      test_mask_withdraw();
      test_level();
      test_w1c_race();
      test_random();
      test_reset_async();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
